// File: rtl/i2c_reg_seq_if.sv
// Bundle of the request/response handshake and the register-slot master bus
// of i2c_reg_seq. The master modport is the sequencer's view; the slave
// modport is the environment's view (requester plus slot device).
interface i2c_reg_seq_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_slave;
  logic [7:0]  req_reg;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  // response channel
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  // register-slot master bus
  logic        m_cs;
  logic        m_read;
  logic        m_write;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_transaction_completed;
  logic [31:0] m_rdata;
  logic        m_rd_done;
  logic        m_wr_done;
  logic        m_slave_error;
  logic        m_decode_error;

  modport master (
    input  req_valid, req_write, req_slave, req_reg, req_len, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output m_cs, m_read, m_write, m_addr, m_wdata, m_transaction_completed,
    input  m_rdata, m_rd_done, m_wr_done, m_slave_error, m_decode_error
  );

  modport slave (
    output req_valid, req_write, req_slave, req_reg, req_len, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  m_cs, m_read, m_write, m_addr, m_wdata, m_transaction_completed,
    output m_rdata, m_rd_done, m_wr_done, m_slave_error, m_decode_error
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: turns one register read/write request into
// the slot-bus accesses that drive an I2C master core (divisor, slave address,
// register byte, data bytes, START/WR/RESTART/RD/STOP commands, status polls).
// Optional macro I2C_REG_SEQ_TIMEOUT_EN: bounds each status poll loop to
// POLL_TIMEOUT cycles and reports error 3 when exceeded.
module i2c_reg_seq #(
  parameter int unsigned DVSR_WIDTH   = 16,
  parameter int unsigned POLL_TIMEOUT = 65535,
  parameter logic [2:0]  CMD_START    = 3'd0,
  parameter logic [2:0]  CMD_WR       = 3'd1,
  parameter logic [2:0]  CMD_RD       = 3'd2,
  parameter logic [2:0]  CMD_STOP     = 3'd3,
  parameter logic [2:0]  CMD_RESTART  = 3'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DVSR_WIDTH-1:0] cfg_dvsr,
  i2c_reg_seq_if.master         bus
);

  localparam logic [7:0] A_RXDATA = 8'h00;
  localparam logic [7:0] A_TXDATA = 8'h04;
  localparam logic [7:0] A_SLAVE  = 8'h08;
  localparam logic [7:0] A_DVSR   = 8'h0C;
  localparam logic [7:0] A_CTRL   = 8'h10;
  localparam logic [7:0] A_STATUS = 8'h14;

  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_SLOT = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_DVSR, S_SLAVE, S_REG, S_WDATA, S_START, S_WR, S_POLL_TX,
    S_RESTART, S_RD_CTRL, S_POLL_RX, S_RD_DATA, S_STOP, S_POLL_IDLE, S_RESP
  } state_t;

  // PH_ACC: slot access in flight; PH_CMPL: completion pulse cycle
  typedef enum logic {PH_ACC, PH_CMPL} phase_t;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic                  write_q, write_d;
  logic [6:0]            slave_q, slave_d;
  logic [7:0]            regaddr_q, regaddr_d;
  logic [1:0]            last_q, last_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;

  logic access_st;
  logic done;
  logic slot_err;
  logic timeout_hit;
  logic acc_rd;
  logic unused_rdata;

  assign access_st    = !(state_q inside {S_IDLE, S_RESP});
  assign done         = bus.m_rd_done | bus.m_wr_done;
  assign slot_err     = bus.m_slave_error | bus.m_decode_error;
  assign unused_rdata = ^bus.m_rdata[31:8];

  function automatic logic [31:0] ctrl_word(input logic [2:0] cmd, input logic ack_en);
    ctrl_word = {25'd0, (cmd != CMD_RD), ack_en, 1'b0, cmd, 1'b1};
  endfunction

  function automatic logic [1:0] keep_first(input logic [1:0] cur, input logic [1:0] code);
    keep_first = (cur == 2'd0) ? code : cur;
  endfunction

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(POLL_TIMEOUT + 1);
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic             in_poll_q, in_poll_d;

  assign in_poll_q   = state_q inside {S_POLL_TX, S_POLL_RX, S_POLL_IDLE};
  assign in_poll_d   = state_d inside {S_POLL_TX, S_POLL_RX, S_POLL_IDLE};
  assign timeout_hit = (poll_cnt_q >= CNT_W'(POLL_TIMEOUT));

  // poll-loop cycle counter, restarted on entry to each poll loop
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (in_poll_d && (state_d != state_q)) begin
      poll_cnt_d = '0;
    end else if (in_poll_q && !timeout_hit) begin
      poll_cnt_d = poll_cnt_q + CNT_W'(1);
    end
  end

  // poll counter register
  always_ff @(posedge clk) begin
    if (rst) poll_cnt_q <= '0;
    else     poll_cnt_q <= poll_cnt_d;
  end
`else
  localparam int unsigned unused_poll_timeout = POLL_TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_ACC;
      write_q   <= 1'b0;
      slave_q   <= '0;
      regaddr_q <= '0;
      last_q    <= '0;
      wdata_q   <= '0;
      dvsr_q    <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      write_q   <= write_d;
      slave_q   <= slave_d;
      regaddr_q <= regaddr_d;
      last_q    <= last_d;
      wdata_q   <= wdata_d;
      dvsr_q    <= dvsr_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // next-state: the step decision is taken on the done cycle so the
  // completion cycle already presents the next step's address and data
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    write_d   = write_q;
    slave_d   = slave_q;
    regaddr_d = regaddr_q;
    last_d    = last_q;
    wdata_d   = wdata_q;
    dvsr_d    = dvsr_q;
    idx_d     = idx_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (state_q == S_IDLE) begin
      if (bus.req_valid) begin
        write_d   = bus.req_write;
        slave_d   = bus.req_slave;
        regaddr_d = bus.req_reg;
        wdata_d   = bus.req_wdata;
        dvsr_d    = cfg_dvsr;
        if (bus.req_len == 3'd0)     last_d = 2'd0;
        else if (bus.req_len > 3'd4) last_d = 2'd3;
        else                         last_d = 2'(bus.req_len - 3'd1);
        idx_d   = '0;
        rdata_d = '0;
        err_d   = '0;
        phase_d = PH_ACC;
        state_d = S_DVSR;
      end
    end else if (state_q == S_RESP) begin
      phase_d = PH_ACC;
      state_d = S_IDLE;
    end else if (phase_q == PH_CMPL) begin
      phase_d = PH_ACC;
    end else if (done) begin
      phase_d = PH_CMPL;
      if (slot_err) begin
        err_d   = keep_first(err_q, ERR_SLOT);
        state_d = (state_q inside {S_STOP, S_POLL_IDLE}) ? S_RESP : S_STOP;
      end else begin
        unique case (state_q)
          S_DVSR:  state_d = S_SLAVE;
          S_SLAVE: state_d = S_REG;
          S_REG:   state_d = write_q ? S_WDATA : S_START;
          S_WDATA: begin
            if (idx_q == last_q) state_d = S_START;
            else                 idx_d   = idx_q + 2'd1;
          end
          S_START: state_d = S_WR;
          S_WR:    state_d = S_POLL_TX;
          S_POLL_TX: begin
            if (bus.m_rdata[2]) begin
              if (timeout_hit) begin
                err_d   = keep_first(err_q, ERR_TMO);
                state_d = S_STOP;
              end
            end else if (!bus.m_rdata[4]) begin
              err_d   = keep_first(err_q, ERR_NACK);
              state_d = S_STOP;
            end else begin
              state_d = write_q ? S_STOP : S_RESTART;
            end
          end
          S_RESTART: begin
            idx_d   = '0;
            state_d = S_RD_CTRL;
          end
          S_RD_CTRL: state_d = S_POLL_RX;
          S_POLL_RX: begin
            if (bus.m_rdata[0]) begin
              state_d = S_RD_DATA;
            end else if (timeout_hit) begin
              err_d   = keep_first(err_q, ERR_TMO);
              state_d = S_STOP;
            end
          end
          S_RD_DATA: begin
            rdata_d[{idx_q, 3'b000} +: 8] = bus.m_rdata[7:0];
            if (idx_q == last_q) begin
              state_d = S_STOP;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_RD_CTRL;
            end
          end
          S_STOP: state_d = S_POLL_IDLE;
          S_POLL_IDLE: begin
            if (!bus.m_rdata[5]) begin
              state_d = S_RESP;
            end else if (timeout_hit) begin
              err_d   = keep_first(err_q, ERR_TMO);
              state_d = S_RESP;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // outputs: slot address/data per step, strobes only while an access is in flight
  always_comb begin
    acc_rd      = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    unique case (state_q)
      S_DVSR:      begin bus.m_addr = A_DVSR;   bus.m_wdata = 32'(dvsr_q); end
      S_SLAVE:     begin bus.m_addr = A_SLAVE;  bus.m_wdata = {25'd0, slave_q}; end
      S_REG:       begin bus.m_addr = A_TXDATA; bus.m_wdata = {24'd0, regaddr_q}; end
      S_WDATA:     begin bus.m_addr = A_TXDATA; bus.m_wdata = {24'd0, wdata_q[{idx_q, 3'b000} +: 8]}; end
      S_START:     begin bus.m_addr = A_CTRL;   bus.m_wdata = ctrl_word(CMD_START, 1'b0); end
      S_WR:        begin bus.m_addr = A_CTRL;   bus.m_wdata = ctrl_word(CMD_WR, 1'b0); end
      S_RESTART:   begin bus.m_addr = A_CTRL;   bus.m_wdata = ctrl_word(CMD_RESTART, 1'b0); end
      S_RD_CTRL:   begin bus.m_addr = A_CTRL;   bus.m_wdata = ctrl_word(CMD_RD, idx_q != last_q); end
      S_STOP:      begin bus.m_addr = A_CTRL;   bus.m_wdata = ctrl_word(CMD_STOP, 1'b0); end
      S_POLL_TX,
      S_POLL_RX,
      S_POLL_IDLE: begin bus.m_addr = A_STATUS; acc_rd = 1'b1; end
      S_RD_DATA:   begin bus.m_addr = A_RXDATA; acc_rd = 1'b1; end
      default: ;
    endcase
    bus.m_cs                    = access_st && (phase_q == PH_ACC);
    bus.m_read                  = bus.m_cs && acc_rd;
    bus.m_write                 = bus.m_cs && !acc_rd;
    bus.m_transaction_completed = (phase_q == PH_CMPL);
    bus.req_ready               = (state_q == S_IDLE);
    bus.rsp_valid               = (state_q == S_RESP);
    bus.rsp_rdata               = rdata_q;
    bus.rsp_err                 = err_q;
  end

endmodule
